// File: rtl/serial_pattern_gen.sv
// Bit-serial pattern transmitter: shifts a PAT_W-bit pattern out MSB first, repeated repeat_cnt times.
// Optional build macro PATGEN_LOAD_EN adds a pat_in port that is latched on start and replaces PATTERN.
module serial_pattern_gen #(
  parameter int                 PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PATTERN = 4'b1010,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
`ifdef PATGEN_LOAD_EN
  input  logic [PAT_W-1:0] pat_in,
`endif
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W    = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [CNT_W-1:0]   r_rep;
  logic [PAT_W-1:0]   r_pat;
  logic               r_w;
  logic               r_w_valid;
  logic               r_busy;
  logic               r_done;

  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [CNT_W-1:0]   w_rep_nxt;
  logic               w_pat_ld;
  logic [PAT_W-1:0]   w_pat_src;
  logic               w_w_nxt;
  logic               w_valid_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;

`ifdef PATGEN_LOAD_EN
  assign w_pat_src = pat_in;
`else
  assign w_pat_src = PATTERN;
`endif

  // Outputs are computed for the cycle after the edge, so every output is a plain flop.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_bit_idx;
    w_rep_nxt   = r_rep;
    w_pat_ld    = 1'b0;
    w_w_nxt     = 1'b0;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_pat_ld = 1'b1;
          if (repeat_cnt == '0) begin
            w_state_nxt = DONE;
            w_idx_nxt   = '0;
            w_rep_nxt   = '0;
            w_busy_nxt  = 1'b1;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = SHIFT;
            w_idx_nxt   = LAST_IDX;
            w_rep_nxt   = repeat_cnt;
            w_w_nxt     = w_pat_src[LAST_IDX];
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
          w_rep_nxt   = '0;
        end else if (r_bit_idx == '0 && r_rep == CNT_W'(1)) begin
          w_state_nxt = DONE;
          w_idx_nxt   = '0;
          w_rep_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b1;
        end else if (r_bit_idx == '0) begin
          w_idx_nxt   = LAST_IDX;
          w_rep_nxt   = r_rep - CNT_W'(1);
          w_w_nxt     = r_pat[LAST_IDX];
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end else begin
          w_idx_nxt   = r_bit_idx - IDX_W'(1);
          w_w_nxt     = r_pat[w_idx_nxt];
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      DONE: begin
        // Completion has already happened; abort here has nothing left to cancel.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
        w_rep_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_bit_idx <= '0;
      r_rep     <= '0;
      r_w       <= 1'b0;
      r_w_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_idx <= w_idx_nxt;
      r_rep     <= w_rep_nxt;
      r_w       <= w_w_nxt;
      r_w_valid <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Pattern holding register is pure data and only ever read after a load.
  always_ff @(posedge clk) begin
    if (w_pat_ld) begin
      r_pat <= w_pat_src;
    end
  end

  assign w       = r_w;
  assign w_valid = r_w_valid;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed self-checking bench for serial_pattern_gen, including a 1010 Moore detector on the serial line.
module tb_serial_pattern_gen;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] repeat_cnt;
  logic       abort;
`ifdef PATGEN_LOAD_EN
  logic [3:0] pat_in;
`endif
  logic       w;
  logic       w_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  serial_pattern_gen #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .repeat_cnt (repeat_cnt),
    .abort      (abort),
`ifdef PATGEN_LOAD_EN
    .pat_in     (pat_in),
`endif
    .w          (w),
    .w_valid    (w_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overlapping Moore 1010 detector fed by the serial line, advancing only on valid bits.
  logic [2:0] det_state;
  logic       det_clr;
  int         z_cnt;
  logic [2:0] det_nxt;
  always_comb begin
    det_nxt = 3'd0;
    case (det_state)
      3'd0: det_nxt = w ? 3'd1 : 3'd0;
      3'd1: det_nxt = w ? 3'd1 : 3'd2;
      3'd2: det_nxt = w ? 3'd3 : 3'd0;
      3'd3: det_nxt = w ? 3'd1 : 3'd4;
      3'd4: det_nxt = w ? 3'd3 : 3'd0;
      default: det_nxt = 3'd0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (det_clr) begin
      det_state <= 3'd0;
      z_cnt     <= 0;
    end else if (w_valid) begin
      det_state <= det_nxt;
      if (det_nxt == 3'd4) z_cnt <= z_cnt + 1;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; repeat_cnt = 8'd0; det_clr = 1'b1;
`ifdef PATGEN_LOAD_EN
    pat_in = 4'b0000;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if ({w, w_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got w/vld/busy/done=%b expected 0000", {w, w_valid, busy, done});
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({w, w_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 0000", {w, w_valid, busy, done});
    end
  endtask

  task automatic test_basic_and_loopback();
    logic [7:0] exp_bits;
    exp_bits = 8'b10101010;
    det_clr = 1'b1;
    @(negedge clk);
    det_clr = 1'b0;
    repeat_cnt = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({w, w_valid, busy, done} !== {exp_bits[7-i], 3'b110}) begin
        errors++;
        $display("FAIL basic_bit%0d: got w/vld/busy/done=%b expected %b", i, {w, w_valid, busy, done}, {exp_bits[7-i], 3'b110});
      end
      @(negedge clk);
    end
    checks++;
    if ({w, w_valid, busy, done} !== 4'b0011) begin
      errors++;
      $display("FAIL basic_done: got %b expected 0011", {w, w_valid, busy, done});
    end
    @(negedge clk);
    checks++;
    if ({w, w_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL basic_idle: got %b expected 0000", {w, w_valid, busy, done});
    end
    checks++;
    if (z_cnt !== 3) begin
      errors++;
      $display("FAIL loopback_z_count: got %0d expected 3", z_cnt);
    end
  endtask

  task automatic test_zero_repeat();
    repeat_cnt = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({w, w_valid, busy, done} !== 4'b0011) begin
      errors++;
      $display("FAIL zero_done: got %b expected 0011", {w, w_valid, busy, done});
    end
    @(negedge clk);
    checks++;
    if ({w, w_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL zero_idle: got %b expected 0000", {w, w_valid, busy, done});
    end
  endtask

  task automatic test_abort();
    logic [4:0] exp_bits;
    int         done_seen;
    exp_bits = 5'b10101;
    done_seen = 0;
    repeat_cnt = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({w, w_valid} !== {exp_bits[4-i], 1'b1}) begin
        errors++;
        $display("FAIL abort_bit%0d: got w/vld=%b expected %b", i, {w, w_valid}, {exp_bits[4-i], 1'b1});
      end
      if (i == 4) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    checks++;
    if ({w, w_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle: got %b expected 0000", {w, w_valid, busy, done});
    end
    for (int i = 0; i < 12; i++) begin
      if (done || w_valid) done_seen++;
      @(negedge clk);
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d active cycles expected 0", done_seen);
    end
    // abort together with start in IDLE must suppress the start
    repeat_cnt = 8'd1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({w_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL abort_beats_start: got vld/busy/done=%b expected 000", {w_valid, busy, done});
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_bits;
    exp_bits = 4'b1010;
    repeat_cnt = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({w, w_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got %b expected 0000", {w, w_valid, busy, done});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    repeat_cnt = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({w, w_valid} !== {exp_bits[3-i], 1'b1}) begin
        errors++;
        $display("FAIL post_reset_bit%0d: got w/vld=%b expected %b", i, {w, w_valid}, {exp_bits[3-i], 1'b1});
      end
      @(negedge clk);
    end
    checks++;
    if ({busy, done} !== 2'b11) begin
      errors++;
      $display("FAIL post_reset_done: got busy/done=%b expected 11", {busy, done});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    repeat_cnt = 8'd1; start = 1'b1;
    @(negedge clk);
    repeat_cnt = 8'd5;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (w_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_first_vld%0d: got %b expected 1", i, w_valid);
      end
      @(negedge clk);
    end
    checks++;
    if ({w_valid, busy, done} !== 3'b011) begin
      errors++;
      $display("FAIL b2b_first_done: got vld/busy/done=%b expected 011", {w_valid, busy, done});
    end
    @(negedge clk);
    checks++;
    if ({w_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_gap: got vld/busy/done=%b expected 000", {w_valid, busy, done});
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({w, w_valid, busy} !== 3'b111) begin
      errors++;
      $display("FAIL b2b_second_start: got w/vld/busy=%b expected 111", {w, w_valid, busy});
    end
    // second burst latched repeat_cnt=5, so it is still running after 8 bits
    repeat (8) @(negedge clk);
    checks++;
    if ({w_valid, busy, done} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_second_len: got vld/busy/done=%b expected 110", {w_valid, busy, done});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

`ifdef PATGEN_LOAD_EN
  task automatic test_pat_load();
    logic [3:0] exp_bits;
    exp_bits = 4'b0110;
    pat_in = 4'b0110; repeat_cnt = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) pat_in = 4'b1111;
      checks++;
      if ({w, w_valid} !== {exp_bits[3-i], 1'b1}) begin
        errors++;
        $display("FAIL load_bit%0d: got w/vld=%b expected %b", i, {w, w_valid}, {exp_bits[3-i], 1'b1});
      end
      @(negedge clk);
    end
    checks++;
    if ({busy, done} !== 2'b11) begin
      errors++;
      $display("FAIL load_done: got busy/done=%b expected 11", {busy, done});
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_and_loopback();
    test_zero_repeat();
    test_abort();
    test_async_reset();
    test_back_to_back();
`ifdef PATGEN_LOAD_EN
    test_pat_load();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
